hsv2rgb_pipe: RTL and testbench

- Converts one HSV pixel per cycle back to RGB, the inverse of the RGB2HSV datapath.
- Sits on the display/output side of the HSV processing chain.
- Fixed 3-stage pipeline with a valid/ready handshake on both sides.
- Integer arithmetic only. Every divide by M = 2^DW-1 uses an exact shift identity; there is no divider.

---
 rtl/hsv2rgb_pipe.sv | 198 +++++++++++++++++++
 tb/tb_hsv2rgb_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv2rgb_pipe.sv
// hsv2rgb_pipe: 3-stage HSV->RGB converter with valid/ready handshake, no divider.
// Optional start-of-frame sideband enabled by defining HSV2RGB_SOF_EN.
module hsv2rgb_pipe #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW+2:0] in_h,
    input  logic [DW-1:0] in_s,
    input  logic [DW-1:0] in_v,
`ifdef HSV2RGB_SOF_EN
    input  logic          in_sof,
    output logic          out_sof,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_g,
    output logic [DW-1:0] out_b
);

    localparam int W2 = 2*DW + 1;
    localparam logic [DW-1:0] M = '1;

    // floor(x / (2^DW-1)), exact for 0 <= x <= M*M
    function automatic logic [DW-1:0] div_m(input logic [W2-1:0] x);
        logic [W2-1:0] sum;
        sum = x + W2'(1) + (x >> DW);
        return sum[2*DW-1:DW];
    endfunction

    function automatic logic [W2-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return W2'(a) * W2'(b);
    endfunction

    logic en;

    logic          s1_valid_q, s1_valid_d;
    logic [2:0]    s1_sec_q,   s1_sec_d;
    logic [DW-1:0] s1_s_q,     s1_s_d;
    logic [DW-1:0] s1_v_q,     s1_v_d;
    logic [DW-1:0] s1_sf_q,    s1_sf_d;
    logic [DW-1:0] s1_sfn_q,   s1_sfn_d;

    logic          s2_valid_q, s2_valid_d;
    logic [2:0]    s2_sec_q,   s2_sec_d;
    logic [DW-1:0] s2_v_q,     s2_v_d;
    logic [DW-1:0] s2_p_q,     s2_p_d;
    logic [DW-1:0] s2_q_q,     s2_q_d;
    logic [DW-1:0] s2_t_q,     s2_t_d;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_r_q,     out_r_d;
    logic [DW-1:0] out_g_q,     out_g_d;
    logic [DW-1:0] out_b_q,     out_b_d;

    logic [2:0]    sec_in;
    logic [DW-1:0] f_in;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;
    assign sec_in   = in_h[DW+2:DW];
    assign f_in     = in_h[DW-1:0];

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sec_d   = s1_sec_q;
        s1_s_d     = s1_s_q;
        s1_v_d     = s1_v_q;
        s1_sf_d    = s1_sf_q;
        s1_sfn_d   = s1_sfn_q;
        if (en) begin
            s1_valid_d = in_valid;
            // sectors 6 and 7 alias onto 0 and 1
            case (sec_in)
                3'd6:    s1_sec_d = 3'd0;
                3'd7:    s1_sec_d = 3'd1;
                default: s1_sec_d = sec_in;
            endcase
            s1_s_d   = in_s;
            s1_v_d   = in_v;
            s1_sf_d  = div_m(mul(in_s, f_in));
            s1_sfn_d = div_m(mul(in_s, M - f_in));
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sec_d   = s2_sec_q;
        s2_v_d     = s2_v_q;
        s2_p_d     = s2_p_q;
        s2_q_d     = s2_q_q;
        s2_t_d     = s2_t_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_sec_d   = s1_sec_q;
            s2_v_d     = s1_v_q;
            s2_p_d     = div_m(mul(s1_v_q, M - s1_s_q));
            s2_q_d     = div_m(mul(s1_v_q, M - s1_sf_q));
            s2_t_d     = div_m(mul(s1_v_q, M - s1_sfn_q));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_g_d     = out_g_q;
        out_b_d     = out_b_q;
        if (en) begin
            out_valid_d = s2_valid_q;
            case (s2_sec_q)
                3'd1: begin out_r_d = s2_q_q; out_g_d = s2_v_q; out_b_d = s2_p_q; end
                3'd2: begin out_r_d = s2_p_q; out_g_d = s2_v_q; out_b_d = s2_t_q; end
                3'd3: begin out_r_d = s2_p_q; out_g_d = s2_q_q; out_b_d = s2_v_q; end
                3'd4: begin out_r_d = s2_t_q; out_g_d = s2_p_q; out_b_d = s2_v_q; end
                3'd5: begin out_r_d = s2_v_q; out_g_d = s2_p_q; out_b_d = s2_q_q; end
                default: begin out_r_d = s2_v_q; out_g_d = s2_t_q; out_b_d = s2_p_q; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sec_q    <= '0;
            s1_s_q      <= '0;
            s1_v_q      <= '0;
            s1_sf_q     <= '0;
            s1_sfn_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sec_q    <= '0;
            s2_v_q      <= '0;
            s2_p_q      <= '0;
            s2_q_q      <= '0;
            s2_t_q      <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_g_q     <= '0;
            out_b_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sec_q    <= s1_sec_d;
            s1_s_q      <= s1_s_d;
            s1_v_q      <= s1_v_d;
            s1_sf_q     <= s1_sf_d;
            s1_sfn_q    <= s1_sfn_d;
            s2_valid_q  <= s2_valid_d;
            s2_sec_q    <= s2_sec_d;
            s2_v_q      <= s2_v_d;
            s2_p_q      <= s2_p_d;
            s2_q_q      <= s2_q_d;
            s2_t_q      <= s2_t_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_g_q     <= out_g_d;
            out_b_q     <= out_b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_g     = out_g_q;
    assign out_b     = out_b_q;

`ifdef HSV2RGB_SOF_EN
    logic s1_sof_q, s1_sof_d;
    logic s2_sof_q, s2_sof_d;
    logic out_sof_q, out_sof_d;

    always_comb begin
        s1_sof_d  = s1_sof_q;
        s2_sof_d  = s2_sof_q;
        out_sof_d = out_sof_q;
        if (en) begin
            s1_sof_d  = in_sof & in_valid;
            s2_sof_d  = s1_sof_q;
            out_sof_d = s2_sof_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sof_q  <= 1'b0;
            s2_sof_q  <= 1'b0;
            out_sof_q <= 1'b0;
        end else begin
            s1_sof_q  <= s1_sof_d;
            s2_sof_q  <= s2_sof_d;
            out_sof_q <= out_sof_d;
        end
    end

    assign out_sof = out_sof_q & out_valid_q;
`endif

endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// Self-checking bench for hsv2rgb_pipe: directed vector table, backpressure,
// mid-stream reset and randomized traffic against an arithmetic HSV->RGB model.
module tb_hsv2rgb_pipe;

    localparam int DW = 8;
    localparam int M  = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW+2:0] in_h;
    logic [DW-1:0] in_s;
    logic [DW-1:0] in_v;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r;
    logic [DW-1:0] out_g;
    logic [DW-1:0] out_b;
`ifdef HSV2RGB_SOF_EN
    logic          in_sof;
    logic          out_sof;
`endif

    always #5 clk = ~clk;

    hsv2rgb_pipe #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_h      (in_h),
        .in_s      (in_s),
        .in_v      (in_v),
`ifdef HSV2RGB_SOF_EN
        .in_sof    (in_sof),
        .out_sof   (out_sof),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b)
    );

    typedef struct {
        logic [3*DW-1:0] rgb;
        bit              sof;
        int              cyc;
    } exp_t;

    typedef struct {
        int              h;
        int              s;
        int              v;
        logic [3*DW-1:0] rgb;
    } vec_t;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    bit use_tab = 0;
    bit lat_chk = 0;
    bit rnd_rdy = 0;
    logic [3*DW-1:0] tab_exp = '0;
    exp_t sbq[$];

    bit              prev_stall = 0;
    logic [3*DW-1:0] prev_rgb = '0;

    task automatic chk(input string nm, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: HSV sector formulas evaluated with plain integer floor division
    function automatic logic [3*DW-1:0] model(input int h, input int s, input int v);
        int sec, f, sf, sfn, p, q, t, r, g, b;
        sec = (h >> DW) % 6;
        f   = h % (1 << DW);
        sf  = (s * f) / M;
        sfn = (s * (M - f)) / M;
        p   = (v * (M - s)) / M;
        q   = (v * (M - sf)) / M;
        t   = (v * (M - sfn)) / M;
        case (sec)
            0: begin r = v; g = t; b = p; end
            1: begin r = q; g = v; b = p; end
            2: begin r = p; g = v; b = t; end
            3: begin r = p; g = q; b = v; end
            4: begin r = t; g = p; b = v; end
            default: begin r = v; g = p; b = q; end
        endcase
        return {DW'(r), DW'(g), DW'(b)};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            sbq.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_stable", {out_r, out_g, out_b}, prev_rgb);
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rgb", {out_r, out_g, out_b}, e.rgb);
                    if (lat_chk) chk("latency", cyc - e.cyc, 3);
`ifdef HSV2RGB_SOF_EN
                    chk("out_sof", out_sof, e.sof);
`endif
                end
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                e.rgb = use_tab ? tab_exp : model(int'(in_h), int'(in_s), int'(in_v));
`ifdef HSV2RGB_SOF_EN
                e.sof = in_sof;
`else
                e.sof = 0;
`endif
                e.cyc = cyc;
                sbq.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_rgb   = {out_r, out_g, out_b};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input int h, input int s, input int v, input bit sof);
        bit acc;
        in_h = (DW+3)'(h);
        in_s = DW'(s);
        in_v = DW'(v);
`ifdef HSV2RGB_SOF_EN
        in_sof = sof;
`else
        if (sof) acc = 0;
`endif
        in_valid = 1;
        acc = 0;
        for (int k = 0; k < 64 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic idle_valid();
        in_valid = 0;
`ifdef HSV2RGB_SOF_EN
        in_sof = 0;
`endif
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sbq.size() != 0; k++) tick();
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        vec_t tab[7];
        int base_acc, base_out;

        tab[0] = '{h: 0,    s: 255, v: 255, rgb: {8'd255, 8'd0,   8'd0}};
        tab[1] = '{h: 128,  s: 255, v: 255, rgb: {8'd255, 8'd128, 8'd0}};
        tab[2] = '{h: 512,  s: 255, v: 200, rgb: {8'd0,   8'd200, 8'd0}};
        tab[3] = '{h: 1000, s: 0,   v: 77,  rgb: {8'd77,  8'd77,  8'd77}};
        tab[4] = '{h: 1535, s: 255, v: 255, rgb: {8'd255, 8'd0,   8'd0}};
        tab[5] = '{h: 1536, s: 255, v: 255, rgb: {8'd255, 8'd0,   8'd0}};
        tab[6] = '{h: 1792, s: 255, v: 255, rgb: {8'd255, 8'd255, 8'd0}};

        rst = 1; out_ready = 1; in_h = '0; in_s = '0; in_v = '0;
        idle_valid();
        repeat (3) tick();
        rst = 0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_rgb", {out_r, out_g, out_b}, 0);
        tick();

        // Directed vectors back-to-back, fixed latency
        use_tab = 1; lat_chk = 1;
        for (int i = 0; i < 7; i++) begin
            tab_exp = tab[i].rgb;
            send(tab[i].h, tab[i].s, tab[i].v, 0);
        end
        idle_valid();
        drain();
        use_tab = 0; lat_chk = 0;

        // Backpressure: only three pixels fit while the consumer stalls
        base_acc = acc_cnt; base_out = out_cnt;
        out_ready = 0;
        for (int i = 0; i < 3; i++)
            send($urandom_range(0, 1535), $urandom_range(0, M), $urandom_range(0, M), 0);
        in_valid = 1;
        repeat (4) tick();
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_accepts", acc_cnt - base_acc, 3);
        tick();
        out_ready = 1;
        send(300, 200, 150, 0);
        send(1400, 90, 240, 0);
        idle_valid();
        drain();
        chk("bp_drained", out_cnt - base_out, 5);

        // Reset with two pixels in flight
        base_out = out_cnt;
        send(700, 255, 255, 0);
        send(900, 128, 64, 0);
        idle_valid();
        rst = 1;
        tick();
        rst = 0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_rgb", {out_r, out_g, out_b}, 0);
        repeat (6) tick();
        chk("rst_mid_no_output", out_cnt - base_out, 0);

        // Random traffic with gaps on both sides
        rnd_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_valid();
                repeat ($urandom_range(1, 3)) tick();
            end
            send($urandom_range(0, 2047), $urandom_range(0, M), $urandom_range(0, M), i == 0);
        end
        idle_valid();
        rnd_rdy = 0;
        out_ready = 1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
